// File: rtl/cpu_pipe_pkg.sv
// cpu_pipe_pkg: shared control bundle and lane vector types for the decode/execute stage
package cpu_pipe_pkg;
   localparam int LANES = 3;
   localparam int WIDTH = 16;
   typedef struct packed {
      logic       pc_src;
      logic       reg_write;
      logic       mem_to_reg;
      logic       mem_write;
      logic       branch;
      logic       alu_src;
      logic       flag_write;
      logic [3:0] alu_control;
   } ctrl_t;
   localparam int CTRL_W = $bits(ctrl_t);
   typedef logic [LANES-1:0][WIDTH-1:0] lane_vec_t;
endpackage

// File: rtl/pipe_entry_reg.sv
// pipe_entry_reg: one payload register with load enable and sync active-low reset
module pipe_entry_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_ld,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);
   logic [W-1:0] r_q;
   always_ff @(posedge clk)
      if (!reset) r_q <= '0;
      else if (i_ld) r_q <= i_d;
   assign o_q = r_q;
endmodule

// File: rtl/pipe_stage_buffer.sv
// pipe_stage_buffer: decode/execute stage register with valid/ready, flush and optional skid entry
module pipe_stage_buffer import cpu_pipe_pkg::*; #(
   parameter int LANES  = 3,
   parameter int WIDTH  = 16,
   parameter int REG_AW = 4,
   parameter int SKID   = 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [LANES-1:0][WIDTH-1:0]  in_src1,
   input  logic [LANES-1:0][WIDTH-1:0]  in_src2,
   input  logic [LANES-1:0][WIDTH-1:0]  in_imm,
   input  ctrl_t                        in_ctrl,
   input  logic [REG_AW-1:0]            in_wa3,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [LANES-1:0][WIDTH-1:0]  out_src1,
   output logic [LANES-1:0][WIDTH-1:0]  out_src2,
   output logic [LANES-1:0][WIDTH-1:0]  out_imm,
   output ctrl_t                        out_ctrl,
   output logic [REG_AW-1:0]            out_wa3,
   output logic [1:0]                   out_count
);
   localparam int PW = 3*LANES*WIDTH + CTRL_W + REG_AW;
   logic          r_main_v, r_skid_v;
   logic          w_acc, w_con, w_ld_main, w_ld_skid;
   logic [PW-1:0] w_in_pay, w_main_d, w_main_q, w_skid_q;
   ctrl_t         w_ctrl;
   assign w_in_pay = {in_src1, in_src2, in_imm, in_ctrl, in_wa3};
   // skid mode derives ready from state only, so out_ready never reaches in_ready
   always_comb begin
      in_ready  = reset & ((SKID != 0) ? !r_skid_v : (!r_main_v | out_ready));
      w_acc     = in_valid & in_ready;
      w_con     = r_main_v & out_ready;
      w_ld_skid = w_acc & r_main_v & !w_con;
      w_ld_main = (w_con & r_skid_v) | (w_acc & (!r_main_v | w_con));
      w_main_d  = r_skid_v ? w_skid_q : w_in_pay;
   end
   always_ff @(posedge clk)
      if (!reset || flush) begin
         r_main_v <= 1'b0;
         r_skid_v <= 1'b0;
      end else begin
         r_main_v <= r_skid_v | w_acc | (r_main_v & !w_con);
         r_skid_v <= w_ld_skid | (r_skid_v & !w_con);
      end
   pipe_entry_reg #(.W(PW)) u_main (
      .clk   (clk),
      .reset (reset),
      .i_ld  (w_ld_main),
      .i_d   (w_main_d),
      .o_q   (w_main_q)
   );
   generate
      if (SKID != 0) begin : g_skid
         pipe_entry_reg #(.W(PW)) u_skid (
            .clk   (clk),
            .reset (reset),
            .i_ld  (w_ld_skid),
            .i_d   (w_in_pay),
            .o_q   (w_skid_q)
         );
      end else begin : g_noskid
         assign w_skid_q = '0;
      end
   endgenerate
   assign {out_src1, out_src2, out_imm, w_ctrl, out_wa3} = w_main_q;
   assign out_valid = r_main_v;
   assign out_ctrl  = r_main_v ? w_ctrl : '0;
   assign out_count = {1'b0, r_main_v} + {1'b0, r_skid_v};
endmodule

// File: tb/tb_pipe_stage_buffer.sv
// tb_pipe_stage_buffer: skid and no-skid builds checked against queue models
module tb_pipe_stage_buffer;
   import cpu_pipe_pkg::*;
   logic clk = 1'b0, reset = 1'b0, flush = 1'b0;
   always #5 clk = ~clk;
   logic                iv_a, ir_a, ov_a, or_a;
   logic [2:0][15:0]    s1_a, s2_a, im_a, os1_a, os2_a, oim_a;
   ctrl_t               c_a, oc_a;
   logic [3:0]          w_a, ow_a;
   logic [1:0]          cnt_a;
   logic                iv_b, ir_b, ov_b, or_b;
   logic [3:0][31:0]    s1_b, s2_b, im_b, os1_b, os2_b, oim_b;
   ctrl_t               c_b, oc_b;
   logic [3:0]          w_b, ow_b;
   logic [1:0]          cnt_b;
   logic [158:0]        pay_a, opay_a;
   logic [398:0]        pay_b, opay_b;
   assign pay_a  = {s1_a, s2_a, im_a, c_a, w_a};
   assign opay_a = {os1_a, os2_a, oim_a, oc_a, ow_a};
   assign pay_b  = {s1_b, s2_b, im_b, c_b, w_b};
   assign opay_b = {os1_b, os2_b, oim_b, oc_b, ow_b};
   pipe_stage_buffer #(.LANES(3), .WIDTH(16), .REG_AW(4), .SKID(1)) u_a (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(iv_a), .in_ready(ir_a),
      .in_src1(s1_a), .in_src2(s2_a), .in_imm(im_a), .in_ctrl(c_a), .in_wa3(w_a),
      .out_valid(ov_a), .out_ready(or_a), .out_src1(os1_a), .out_src2(os2_a),
      .out_imm(oim_a), .out_ctrl(oc_a), .out_wa3(ow_a), .out_count(cnt_a)
   );
   pipe_stage_buffer #(.LANES(4), .WIDTH(32), .REG_AW(4), .SKID(0)) u_b (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(iv_b), .in_ready(ir_b),
      .in_src1(s1_b), .in_src2(s2_b), .in_imm(im_b), .in_ctrl(c_b), .in_wa3(w_b),
      .out_valid(ov_b), .out_ready(or_b), .out_src1(os1_b), .out_src2(os2_b),
      .out_imm(oim_b), .out_ctrl(oc_b), .out_wa3(ow_b), .out_count(cnt_b)
   );
   int checks = 0, errors = 0;
   bit chk_en = 1'b0;
   logic [158:0] qa[$];
   logic [398:0] qb[$];
   task automatic chk(input string n, input logic [398:0] act, input logic [398:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", n, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #2;
   endtask
   task automatic rnd_a();
      for (int l = 0; l < 3; l++) begin
         s1_a[l] = 16'($urandom);
         s2_a[l] = 16'($urandom);
         im_a[l] = 16'($urandom);
      end
      c_a = ctrl_t'(11'($urandom));
      w_a = 4'($urandom);
   endtask
   task automatic rnd_b();
      for (int l = 0; l < 4; l++) begin
         s1_b[l] = $urandom;
         s2_b[l] = $urandom;
         im_b[l] = $urandom;
      end
      c_b = ctrl_t'(11'($urandom));
      w_b = 4'($urandom);
   endtask
   // FIFO models: skid build holds up to two entries, plain build holds one
   always @(posedge clk) begin : model
      automatic bit acc_a = iv_a && (qa.size() < 2);
      automatic bit con_a = or_a && (qa.size() > 0);
      automatic bit acc_b = iv_b && (qb.size() == 0 || or_b);
      automatic bit con_b = or_b && (qb.size() > 0);
      if (!reset || flush) begin
         qa.delete();
         qb.delete();
      end else begin
         if (con_a) void'(qa.pop_front());
         if (acc_a) qa.push_back(pay_a);
         if (con_b) void'(qb.pop_front());
         if (acc_b) qb.push_back(pay_b);
      end
   end
   always @(negedge clk) if (chk_en) begin
      chk("a_in_ready", 399'(ir_a), 399'(reset && qa.size() < 2));
      chk("a_out_valid", 399'(ov_a), 399'(qa.size() > 0));
      chk("a_count", 399'(cnt_a), 399'(qa.size()));
      if (qa.size() > 0) chk("a_payload", 399'(opay_a), 399'(qa[0]));
      else chk("a_ctrl_gated", 399'(oc_a), 399'(0));
      chk("b_in_ready", 399'(ir_b), 399'(reset && (qb.size() == 0 || or_b)));
      chk("b_out_valid", 399'(ov_b), 399'(qb.size() > 0));
      chk("b_count", 399'(cnt_b), 399'(qb.size()));
      if (qb.size() > 0) chk("b_payload", opay_b, qb[0]);
      else chk("b_ctrl_gated", 399'(oc_b), 399'(0));
   end
   initial begin
      iv_b = 1'b0;
      or_b = 1'b0;
      rnd_b();
      forever begin
         tick();
         iv_b = ($urandom_range(0, 3) != 0);
         or_b = ($urandom_range(0, 2) != 0);
         rnd_b();
      end
   end
   initial begin
      iv_a = 1'b1;
      or_a = 1'b0;
      rnd_a();
      @(posedge clk);
      #1 chk_en = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 399'(ov_a), 399'(0));
      chk("rst_out_ctrl", 399'(oc_a), 399'(0));
      chk("rst_count", 399'(cnt_a), 399'(0));
      chk("rst_in_ready", 399'(ir_a), 399'(0));
      tick();
      reset = 1'b1;
      iv_a = 1'b0;
      @(negedge clk);
      chk("rel_in_ready", 399'(ir_a), 399'(1));
      for (int i = 1; i <= 8; i++) begin
         tick();
         rnd_a();
         s1_a[0] = 16'(i);
         iv_a = 1'b1;
         or_a = 1'b1;
         @(negedge clk);
         if (i > 1) chk("stream_data", 399'(os1_a[0]), 399'(i - 1));
         chk("stream_count_le1", 399'(cnt_a <= 2'd1), 399'(1));
      end
      tick();
      iv_a = 1'b0;
      @(negedge clk);
      chk("stream_last", 399'(os1_a[0]), 399'(16'h0008));
      tick();
      tick();
      or_a = 1'b0;
      rnd_a();
      s1_a[0] = 16'h00A1;
      iv_a = 1'b1;
      tick();
      rnd_a();
      s1_a[0] = 16'h00A2;
      tick();
      rnd_a();
      s1_a[0] = 16'h00A3;
      @(negedge clk);
      chk("bp_count", 399'(cnt_a), 399'(2));
      chk("bp_in_ready", 399'(ir_a), 399'(0));
      chk("bp_head", 399'(os1_a[0]), 399'(16'h00A1));
      tick();
      @(negedge clk);
      chk("bp_stall_head", 399'(os1_a[0]), 399'(16'h00A1));
      tick();
      or_a = 1'b1;
      tick();
      @(negedge clk);
      chk("bp_second", 399'(os1_a[0]), 399'(16'h00A2));
      chk("bp_ready_back", 399'(ir_a), 399'(1));
      tick();
      iv_a = 1'b0;
      @(negedge clk);
      chk("bp_third", 399'(os1_a[0]), 399'(16'h00A3));
      tick();
      @(negedge clk);
      chk("bp_drained", 399'(ov_a), 399'(0));
      or_a = 1'b0;
      rnd_a();
      s1_a[0] = 16'h0B01;
      iv_a = 1'b1;
      tick();
      rnd_a();
      s1_a[0] = 16'h0B02;
      tick();
      rnd_a();
      s1_a[0] = 16'h0B03;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      iv_a = 1'b0;
      @(negedge clk);
      chk("flush_valid", 399'(ov_a), 399'(0));
      chk("flush_count", 399'(cnt_a), 399'(0));
      chk("flush_ctrl", 399'(oc_a), 399'(0));
      or_a = 1'b1;
      repeat (3) begin
         tick();
         @(negedge clk);
         chk("flush_no_emerge", 399'(ov_a), 399'(0));
      end
      tick();
      c_a = '0;
      c_a.reg_write = 1'b1;
      c_a.mem_write = 1'b1;
      @(negedge clk);
      chk("gate_idle", 399'(oc_a), 399'(0));
      tick();
      iv_a = 1'b1;
      tick();
      iv_a = 1'b0;
      or_a = 1'b0;
      @(negedge clk);
      chk("gate_reg_write", 399'(oc_a.reg_write), 399'(1));
      chk("gate_mem_write", 399'(oc_a.mem_write), 399'(1));
      repeat (1000) begin
         tick();
         rnd_a();
         iv_a = ($urandom_range(0, 3) != 0);
         or_a = ($urandom_range(0, 2) != 0);
         flush = ($urandom_range(0, 49) == 0);
      end
      tick();
      flush = 1'b0;
      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
